lcd_stream_ctrl: RTL and testbench

- Parametrised HD44780-class character-LCD controller.
- Successor to the fixed-mode LCD1602 driver: the processor no longer selects a canned mode. It streams arbitrary characters and commands through a buffered valid/ready port.
- Sits between a Nios PIO/Avalon bridge and the LCD pins.
- Performs power-on init, all bus timing, busy pacing and automatic line wrap for any COLS x ROWS panel.

---
 rtl/lcd_stream_ctrl_if.sv | 10 +
 rtl/lcd_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_lcd_stream_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_stream_ctrl_if.sv
// Write-stream bundle from the host bridge into lcd_stream_ctrl: 9-bit entries, valid/ready.
// master = host side, slave = controller side.
interface lcd_stream_ctrl_if;
    logic       wr_valid;
    logic [8:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/lcd_stream_ctrl.sv
// HD44780 character-LCD stream controller with power-on init, bus pacing and input FIFO; LCD_AUTOWRAP_EN adds cursor tracking with wrap commands.
// Latency: one IDLE cycle from FIFO head to SETUP; backpressure: wr_ready low until init_done and while the FIFO is full.

module lcd_stream_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = AW1'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
        end
    end
endmodule

module lcd_stream_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int INIT_MS    = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lcd_stream_ctrl_if.slave     wr,
    output logic                 init_done,
    output logic                 busy,
    input  logic                 bl_on,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_en,
    output logic [7:0]           lcd_dat,
    output logic                 lcd_bl_p,
    output logic                 lcd_bl_n
);
    localparam int US_TICKS = CLK_HZ / 1000000;
    localparam logic [31:0] PWR_LAST   = 32'(INIT_MS * 1000 * US_TICKS - 1);
    localparam logic [31:0] TICK_LAST  = 32'(US_TICKS - 1);
    localparam logic [31:0] LONG_LAST  = 32'(1640 * US_TICKS - 1);
    localparam logic [31:0] SHORT_LAST = 32'(40 * US_TICKS - 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, EN_HI, HOLD, EXEC} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  init_idx;
    logic        long_wait;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [8:0]  fifo_dat;
    logic        wrap_pend;
    logic [7:0]  wrap_cmd;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    assign wr.wr_ready = init_done && !fifo_full;
    assign fifo_pop    = (state == IDLE) && !wrap_pend && !fifo_empty;
    assign busy        = !((state == IDLE) && fifo_empty && !wrap_pend);
    assign lcd_rw      = 1'b0;
    assign lcd_bl_n    = 1'b0;

    lcd_stream_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (wr.wr_valid && wr.wr_ready),
        .push_dat (wr.wr_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef LCD_AUTOWRAP_EN
    logic [5:0] col, col_nx;
    logic [1:0] row, row_nx;
    logic       wrap_nx;

    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    // Tracker follows the entry being popped; lowest matching row wins on overlap.
    always_comb begin
        col_nx  = col;
        row_nx  = row;
        wrap_nx = 1'b0;
        if (!fifo_dat[8]) begin
            if (col == 6'(COLS - 1)) begin
                col_nx  = '0;
                row_nx  = (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;
                wrap_nx = 1'b1;
            end else begin
                col_nx = col + 6'd1;
            end
        end else if (fifo_dat[7:0] inside {8'h01, 8'h02, 8'h03}) begin
            col_nx = '0;
            row_nx = '0;
        end else if (fifo_dat[7]) begin
            for (int r = ROWS - 1; r >= 0; r--) begin
                if (fifo_dat[6:0] >= row_base(2'(r)) &&
                    {1'b0, fifo_dat[6:0]} < ({1'b0, row_base(2'(r))} + 8'(COLS))) begin
                    row_nx = 2'(r);
                    col_nx = 6'(fifo_dat[6:0] - row_base(2'(r)));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            wrap_pend <= 1'b0;
        end else if (fifo_pop) begin
            col       <= col_nx;
            row       <= row_nx;
            wrap_pend <= wrap_nx;
        end else if (state == IDLE && wrap_pend) begin
            wrap_pend <= 1'b0;
        end
    end

    assign wrap_cmd = {1'b1, row_base(row)};
`else
    assign wrap_pend = 1'b0;
    assign wrap_cmd  = 8'h80;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_bl_p <= 1'b0;
        end else begin
            lcd_bl_p <= bl_on;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PWR_WAIT;
            cnt       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            long_wait <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_dat   <= '0;
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= INIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT: begin
                    if (init_idx == 3'd4) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        lcd_rs    <= 1'b0;
                        lcd_dat   <= init_byte(init_idx[1:0]);
                        long_wait <= (init_idx == 3'd3);
                        init_idx  <= init_idx + 3'd1;
                        state     <= SETUP;
                    end
                end
                IDLE: begin
                    if (wrap_pend) begin
                        lcd_rs    <= 1'b0;
                        lcd_dat   <= wrap_cmd;
                        long_wait <= 1'b0;
                        state     <= SETUP;
                    end else if (!fifo_empty) begin
                        lcd_rs    <= !fifo_dat[8];
                        lcd_dat   <= fifo_dat[7:0];
                        long_wait <= fifo_dat[8] && (fifo_dat[7:0] inside {8'h01, 8'h02, 8'h03});
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == TICK_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b1;
                        state  <= EN_HI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EN_HI: begin
                    if (cnt == TICK_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (cnt == TICK_LAST) begin
                        cnt   <= '0;
                        state <= EXEC;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EXEC: begin
                    if (cnt == (long_wait ? LONG_LAST : SHORT_LAST)) begin
                        cnt   <= '0;
                        state <= init_done ? IDLE : INIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Bench for lcd_stream_ctrl at 1 MHz: directed writes, expected strobes queued by hand, a
// negedge monitor pops and checks each lcd_en strobe plus its setup, width and gap timing.
module tb_lcd_stream_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       bl_on;
    logic       init_done, busy;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_bl_p, lcd_bl_n;
    logic [7:0] lcd_dat;

    lcd_stream_ctrl_if wif();

    lcd_stream_ctrl #(
        .CLK_HZ(1000000), .COLS(16), .ROWS(2), .FIFO_DEPTH(16), .INIT_MS(15)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr        (wif),
        .init_done (init_done),
        .busy      (busy),
        .bl_on     (bl_on),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat   (lcd_dat),
        .lcd_bl_p  (lcd_bl_p),
        .lcd_bl_n  (lcd_bl_n)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_fall = 0;
    int         min_low = 15000;
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic exp_push(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b});
    endtask

    // Strobe monitor: byte order, setup time, enable width and inter-strobe gap.
    initial begin : monitor
        int         low_run = 0;
        int         high_run = 0;
        int         age = 0;
        logic       prev_en = 1'b0;
        logic [8:0] bus, prev_bus = 9'h0, last_strobe = 9'h1FF, want;
        forever begin
            @(negedge clk);
            bus = {lcd_rs, lcd_dat};
            if (bus != prev_bus) age = 0;
            else age++;
            prev_bus = bus;
            if (lcd_en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    chk_eq("strobe_unexpected", {23'd0, bus}, 32'h1FF);
                end else begin
                    want = exp_q.pop_front();
                    chk_eq("strobe_byte", {23'd0, bus}, {23'd0, want});
                end
                chk_eq("strobe_rw", {31'd0, lcd_rw}, 32'd0);
                chk_rng("strobe_gap", low_run, min_low, 1000000);
                if (bus != last_strobe) chk_eq("setup_cycles", age, 1);
                last_strobe = bus;
                min_low  = (!bus[8] && (bus[7:0] inside {8'h01, 8'h02, 8'h03})) ? 1643 : 43;
                high_run = 0;
            end
            if (!lcd_en && prev_en) begin
                chk_eq("en_width", high_run, 1);
                low_run   = 0;
                last_fall = cyc;
            end
            if (lcd_en) high_run++;
            else low_run++;
            prev_en = lcd_en;
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 80000 cycles, queue=%0d", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [8:0] d);
        int t = 0;
        wif.wr_valid = 1'b1;
        wif.wr_data  = d;
        while (!wif.wr_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("send_ready", {31'd0, wif.wr_ready}, 32'd1);
        @(negedge clk);
        wif.wr_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk_eq(name, 32'(exp_q.size()) + {31'd0, busy}, 32'd0);
    endtask

    task automatic quiet(input string name);
        int bad = 0;
        repeat (15000) begin
            @(negedge clk);
            if (lcd_en || wif.wr_ready) bad++;
        end
        chk_eq(name, bad, 0);
    endtask

    task automatic wait_init(input string name);
        int t = 0;
        while (!init_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk_eq({name, "_done"}, {31'd0, init_done}, 32'd1);
        chk_eq({name, "_strobes"}, 32'(exp_q.size()), 32'd0);
        chk_rng({name, "_gap"}, cyc - last_fall, 1640, 1660);
    endtask

    task automatic exp_init();
        exp_push(1'b0, 8'h38);
        exp_push(1'b0, 8'h0C);
        exp_push(1'b0, 8'h06);
        exp_push(1'b0, 8'h01);
    endtask

    initial begin : stim
        logic [8:0] d;
        int         t, stalls, acc;
        reset_n      = 1'b0;
        bl_on        = 1'b1;
        wif.wr_valid = 1'b0;
        wif.wr_data  = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_rs",   {31'd0, lcd_rs},   32'd0);
        chk_eq("rst_rw",   {31'd0, lcd_rw},   32'd0);
        chk_eq("rst_en",   {31'd0, lcd_en},   32'd0);
        chk_eq("rst_dat",  {24'd0, lcd_dat},  32'd0);
        chk_eq("rst_bl_p", {31'd0, lcd_bl_p}, 32'd0);
        chk_eq("rst_bl_n", {31'd0, lcd_bl_n}, 32'd0);
        chk_eq("rst_ready", {31'd0, wif.wr_ready}, 32'd0);
        chk_eq("rst_init_done", {31'd0, init_done}, 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd1);
        exp_init();
        reset_n = 1'b1;
        quiet("pwr_wait_quiet");
        chk_eq("bl_follows", {31'd0, lcd_bl_p}, 32'd1);
        wait_init("init");

        // Single character: RS=1, one setup cycle, one-cycle enable.
        exp_push(1'b1, 8'h41);
        send(9'h041);
        chk_eq("busy_after_write", {31'd0, busy}, 32'd1);
        drain("drain_char", 300);

        // Fill the FIFO while a clear command stalls the bus.
        exp_push(1'b0, 8'h01);
        send(9'h101);
        repeat (3) @(negedge clk);
        stalls = 0;
        acc = 0;
        wif.wr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = (i < 15) ? {1'b0, 8'(8'h61 + i)} : {1'b1, 8'(8'h0B + i)};
            exp_push(!d[8], d[7:0]);
            wif.wr_data = d;
            t = 0;
            while (!wif.wr_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (i < 16) stalls += t;
            @(negedge clk);
            acc++;
            if (acc == 16) chk_eq("full_after_16", {31'd0, wif.wr_ready}, 32'd0);
        end
        wif.wr_valid = 1'b0;
        chk_eq("no_stall_first_16", stalls, 0);
        drain("drain_fifo", 4000);

        // Home, then 33 characters across two wraps.
        exp_push(1'b0, 8'h02);
        send(9'h102);
        for (int i = 0; i < 33; i++) begin
`ifdef LCD_AUTOWRAP_EN
            if (i == 16) exp_push(1'b0, 8'hC0);
            if (i == 32) exp_push(1'b0, 8'h80);
`endif
            exp_push(1'b1, 8'(8'h30 + i));
            send({1'b0, 8'(8'h30 + i)});
        end
        drain("drain_wrap33", 4000);

        // Cursor to row 1 col 5, then 12 characters.
        exp_push(1'b0, 8'hC5);
        send(9'h1C5);
        for (int i = 0; i < 12; i++) begin
`ifdef LCD_AUTOWRAP_EN
            if (i == 11) exp_push(1'b0, 8'h80);
`endif
            exp_push(1'b1, 8'(8'h41 + i));
            send({1'b0, 8'(8'h41 + i)});
        end
        drain("drain_addr", 1500);

        // Address matching no row leaves the tracker at row 0 col 1.
        exp_push(1'b0, 8'hFF);
        send(9'h1FF);
        for (int i = 0; i < 15; i++) begin
            exp_push(1'b1, 8'(8'h61 + i));
            send({1'b0, 8'(8'h61 + i)});
        end
`ifdef LCD_AUTOWRAP_EN
        exp_push(1'b0, 8'hC0);
`endif
        drain("drain_nomatch", 1500);

        // Reset during EN_HI.
        for (int i = 0; i < 5; i++) begin
            exp_push(1'b1, 8'(8'h31 + i));
            send({1'b0, 8'(8'h31 + i)});
        end
        t = 0;
        while (!lcd_en && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk_eq("en_before_reset", {31'd0, lcd_en}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("async_en", {31'd0, lcd_en}, 32'd0);
        chk_eq("async_dat", {24'd0, lcd_dat}, 32'd0);
        chk_eq("async_ready", {31'd0, wif.wr_ready}, 32'd0);
        chk_eq("async_init_done", {31'd0, init_done}, 32'd0);
        chk_eq("async_busy", {31'd0, busy}, 32'd1);
        exp_q.delete();
        min_low = 15000;
        exp_init();
        @(negedge clk);
        reset_n = 1'b1;
        quiet("rerun_pwr_wait_quiet");
        wait_init("reinit");
        exp_push(1'b1, 8'h5A);
        send(9'h05A);
        drain("drain_post_reset", 300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
